// File: rtl/buzz_pkg.sv
// Shared definitions for the note scheduler: note codes, FSM states, record depth
// and the key-priority helper used to pick the lowest pressed key.
package buzz_pkg;

    localparam logic [1:0] NOTE_C4  = 2'd0;
    localparam logic [1:0] NOTE_E4  = 2'd1;
    localparam logic [1:0] NOTE_AB4 = 2'd2;
    localparam logic [1:0] NOTE_C5  = 2'd3;

    localparam int REC_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_GAP   = 3'd2,
        ST_RPLAY = 3'd3,
        ST_RGAP  = 3'd4
    } state_t;

    // Lowest set key index wins when several keys are pressed together.
    function automatic logic [1:0] lowest_key(input logic [3:0] keys);
        casez (keys)
            4'b???1: return NOTE_C4;
            4'b??10: return NOTE_E4;
            4'b?100: return NOTE_AB4;
            default: return NOTE_C5;
        endcase
    endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter shared by hold and gap timing; done is high while the
// count sits at zero, so a load of N-1 gives a done edge after N cycles.
module note_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/note_scheduler.sv
// Buzzer note scheduler: plays the lowest pressed key with a minimum hold and a
// fixed gap. Define NOTE_SCHEDULER_REPLAY_EN to build the 16-note record/replay buffer.
module note_scheduler
    import buzz_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int HOLD_MS = 100,
    parameter int GAP_MS  = 20
) (
    input  logic       clk_50MHz,
    input  logic       reset_button,
    input  logic [3:0] key_req,
    input  logic       replay,
    output logic [1:0] note_sel,
    output logic       note_en,
    output logic       busy,
    output logic [4:0] rec_count
);

    localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int MAX_CYC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    // The timer only ever holds a load value of (cycles - 1).
    localparam int TIMER_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYC - 1);

    state_t               state_reg;
    state_t               state_next;
    logic [1:0]           note_sel_reg;
    logic                 note_en_reg;
    logic                 note_en_next;
    logic                 busy_reg;
    logic                 sel_load;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_done;
    logic                 replay_go;
    logic                 replay_last;

`ifdef NOTE_SCHEDULER_REPLAY_EN
    logic [1:0] rec_mem [REC_DEPTH];
    logic [4:0] rec_count_reg;
    logic [3:0] ptr_reg;
    logic [3:0] rd_addr;
    logic       rd_en;
    logic       rec_wr;

    assign replay_go   = replay && (rec_count_reg != 5'd0);
    assign replay_last = ({1'b0, ptr_reg} == (rec_count_reg - 5'd1));
    assign rd_en       = (state_next == ST_RPLAY) && (state_reg != ST_RPLAY);
    assign rd_addr     = (state_reg == ST_IDLE) ? 4'd0 : ptr_reg + 4'd1;
    assign rec_wr      = sel_load && (rec_count_reg < 5'(REC_DEPTH));
    assign rec_count   = rec_count_reg;
`else
    logic unused_replay;

    assign unused_replay = replay;
    assign replay_go     = 1'b0;
    assign replay_last   = 1'b1;
    assign rec_count     = 5'd0;
`endif

    note_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk_50MHz),
        .srst     (reset_button),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk_50MHz) begin
        if (reset_button) begin
            state_reg    <= ST_IDLE;
            note_sel_reg <= NOTE_C4;
            note_en_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            note_en_reg <= note_en_next;
            busy_reg    <= (state_next != ST_IDLE);
            if (sel_load) begin
                note_sel_reg <= lowest_key(key_req);
            end
`ifdef NOTE_SCHEDULER_REPLAY_EN
            else if (rd_en) begin
                note_sel_reg <= rec_mem[rd_addr];
            end
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (replay_go) begin
                    state_next = ST_RPLAY;
                end else if (|key_req) begin
                    state_next = ST_PLAY;
                end
            end
            // Other keys are ignored; only the latched key can extend the note.
            ST_PLAY: begin
                if (timer_done && !key_req[note_sel_reg]) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RPLAY: begin
                if (timer_done) begin
                    state_next = ST_RGAP;
                end
            end
            ST_RGAP: begin
                if (timer_done) begin
                    state_next = replay_last ? ST_IDLE : ST_RPLAY;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        note_en_next = (state_next == ST_PLAY) || (state_next == ST_RPLAY);
        sel_load     = (state_reg == ST_IDLE) && (state_next == ST_PLAY);
        timer_load   = (state_next != state_reg);
        timer_val    = ((state_next == ST_GAP) || (state_next == ST_RGAP)) ? GAP_LOAD : HOLD_LOAD;
    end

`ifdef NOTE_SCHEDULER_REPLAY_EN
    always_ff @(posedge clk_50MHz) begin
        if (rec_wr) begin
            rec_mem[rec_count_reg[3:0]] <= lowest_key(key_req);
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset_button) begin
            rec_count_reg <= 5'd0;
            ptr_reg       <= 4'd0;
        end else begin
            if (rec_wr) begin
                rec_count_reg <= rec_count_reg + 5'd1;
            end
            if (rd_en) begin
                ptr_reg <= rd_addr;
            end
        end
    end
`endif

    assign note_sel = note_sel_reg;
    assign note_en  = note_en_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler (CLK_HZ=1000, HOLD_MS=4, GAP_MS=2) against a
// cycle-counting reference model; replay scenarios follow NOTE_SCHEDULER_REPLAY_EN.
module tb_note_scheduler;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
`ifdef NOTE_SCHEDULER_REPLAY_EN
    localparam bit REPLAY_ON = 1'b1;
`else
    localparam bit REPLAY_ON = 1'b0;
`endif

    logic       clk_50MHz = 1'b0;
    logic       reset_button = 1'b1;
    logic [3:0] key_req = 4'd0;
    logic       replay = 1'b0;
    logic [1:0] note_sel;
    logic       note_en;
    logic       busy;
    logic [4:0] rec_count;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle 1=play 2=gap 3=replay-play 4=replay-gap,
    // m_elapsed counts cycles already spent in the current phase.
    int         m_phase = 0;
    int         m_elapsed = 0;
    int         m_idx = 0;
    logic [1:0] m_sel = 2'd0;
    logic       m_en = 1'b0;
    logic [1:0] m_rec[$];

    always #5 clk_50MHz = ~clk_50MHz;

    note_scheduler #(
        .CLK_HZ  (1000),
        .HOLD_MS (4),
        .GAP_MS  (2)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset_button (reset_button),
        .key_req      (key_req),
        .replay       (replay),
        .note_sel     (note_sel),
        .note_en      (note_en),
        .busy         (busy),
        .rec_count    (rec_count)
    );

    task automatic model_step(input logic r, input logic [3:0] k, input logic rp);
        logic [1:0] pick;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_idx = 0; m_sel = 2'd0; m_en = 1'b0;
            m_rec.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (REPLAY_ON && rp && m_rec.size() > 0) begin
                        m_phase = 3; m_idx = 0; m_sel = m_rec[0]; m_en = 1'b1; m_elapsed = 1;
                    end else if (k != 4'd0) begin
                        pick = 2'd3;
                        for (int b = 3; b >= 0; b--) if (k[b]) pick = 2'(b);
                        m_phase = 1; m_sel = pick; m_en = 1'b1; m_elapsed = 1;
                        if (REPLAY_ON && m_rec.size() < 16) m_rec.push_back(pick);
                    end
                end
                1: begin
                    if (m_elapsed >= HOLD && !k[m_sel]) begin
                        m_phase = 2; m_en = 1'b0; m_elapsed = 1;
                    end else m_elapsed++;
                end
                2: begin
                    if (m_elapsed >= GAP) m_phase = 0; else m_elapsed++;
                end
                3: begin
                    if (m_elapsed >= HOLD) begin
                        m_phase = 4; m_en = 1'b0; m_elapsed = 1;
                    end else m_elapsed++;
                end
                default: begin
                    if (m_elapsed >= GAP) begin
                        if (m_idx == m_rec.size() - 1) m_phase = 0;
                        else begin
                            m_idx++; m_phase = 3; m_sel = m_rec[m_idx]; m_en = 1'b1; m_elapsed = 1;
                        end
                    end else m_elapsed++;
                end
            endcase
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {m_sel, m_en, (m_phase != 0), 5'(m_rec.size())};
    endfunction

    task automatic step(input logic r, input logic [3:0] k, input logic rp);
        reset_button = r; key_req = k; replay = rp;
        @(posedge clk_50MHz);
        model_step(r, k, rp);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        checks++;
        if ({note_sel, note_en, busy, rec_count} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", {note_sel, note_en, busy, rec_count}, 9'd0);
        end
        $display("reset: sel=%0d en=%0d busy=%0d rec=%0d", note_sel, note_en, busy, rec_count);
    endtask

    task automatic test_tap();
        int en_cycles = 0;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i == 0) ? 4'b0001 : 4'b0000, 1'b0);
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL tap cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1) en_cycles++;
        end
        checks++;
        if (en_cycles != HOLD) begin
            errors++;
            $display("FAIL tap_len got=%0d want=%0d", en_cycles, HOLD);
        end
        $display("tap: note_sel=%0d en_cycles=%0d busy=%0d", note_sel, en_cycles, busy);
    endtask

    task automatic test_priority();
        logic [1:0] starts[$];
        logic       prev_en = 1'b0;
        logic [3:0] k;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            k = (i < 2) ? 4'b1010 : (i < 5) ? 4'b1011 : (i < 14) ? 4'b0001 : 4'b0000;
            step(1'b0, k, 1'b0);
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL priority cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1 && !prev_en) starts.push_back(note_sel);
            prev_en = (note_en === 1'b1);
        end
        checks++;
        if (starts.size() != 2) begin
            errors++;
            $display("FAIL priority_notes got=%0d want=2", starts.size());
        end else begin
            checks++;
            if (starts[0] !== 2'd1 || starts[1] !== 2'd0) begin
                errors++;
                $display("FAIL priority_order got=%0d,%0d want=1,0", starts[0], starts[1]);
            end
        end
        $display("priority: notes=%0d", starts.size());
    endtask

    task automatic test_long_hold();
        int en_cycles = 0;
        int gap_cycles = 0;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, (i < 10) ? 4'b0100 : 4'b0000, 1'b0);
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1) en_cycles++;
            if (busy === 1'b1 && note_en === 1'b0) gap_cycles++;
        end
        checks++;
        if (en_cycles != 10 || gap_cycles != GAP) begin
            errors++;
            $display("FAIL long_hold_len got=%0d/%0d want=10/%0d", en_cycles, gap_cycles, GAP);
        end
        $display("long_hold: en_cycles=%0d gap_cycles=%0d", en_cycles, gap_cycles);
    endtask

    task automatic test_reset_mid_note();
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        checks++;
        if ({note_sel, note_en, busy} !== 4'b1111) begin
            errors++;
            $display("FAIL mid_note_play got=%b want=1111", {note_sel, note_en, busy});
        end
        step(1'b1, 4'b1000, 1'b0);
        checks++;
        if ({note_sel, note_en, busy, rec_count} !== 9'd0) begin
            errors++;
            $display("FAIL mid_note_reset got=%b want=%b", {note_sel, note_en, busy, rec_count}, 9'd0);
        end
        $display("reset_mid_note: sel=%0d en=%0d busy=%0d rec=%0d", note_sel, note_en, busy, rec_count);
    endtask

    task automatic test_back_to_back();
        logic [1:0] starts[$];
        logic       prev_en = 1'b0;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i < 1) ? 4'b0100 : (i < 14) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1 && !prev_en) starts.push_back(note_sel);
            prev_en = (note_en === 1'b1);
        end
        checks++;
        if (starts.size() != 2) begin
            errors++;
            $display("FAIL back_to_back_notes got=%0d want=2", starts.size());
        end else begin
            checks++;
            if (starts[0] !== 2'd2 || starts[1] !== 2'd1) begin
                errors++;
                $display("FAIL back_to_back_order got=%0d,%0d want=2,1", starts[0], starts[1]);
            end
        end
        $display("back_to_back: notes=%0d", starts.size());
    endtask

`ifdef NOTE_SCHEDULER_REPLAY_EN
    task automatic test_replay();
        logic [3:0] taps[3] = '{4'b0001, 4'b1000, 4'b0010};
        logic [1:0] starts[$];
        int         runs[$];
        logic       prev_en = 1'b0;
        step(1'b1, 4'd0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 9; i++) begin
                step(1'b0, (i == 0) ? taps[n] : 4'b0000, 1'b0);
                checks++;
                if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                    errors++;
                    $display("FAIL replay_rec n=%0d cyc=%0d got=%b want=%b", n, i, {note_sel, note_en, busy, rec_count}, exp_vec());
                end
            end
        end
        checks++;
        if (rec_count !== 5'd3) begin
            errors++;
            $display("FAIL replay_count got=%0d want=3", rec_count);
        end
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 4'b0000, (i == 0));
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL replay_run cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1 && !prev_en) begin
                starts.push_back(note_sel);
                runs.push_back(0);
            end
            if (note_en === 1'b1) runs[runs.size() - 1]++;
            prev_en = (note_en === 1'b1);
        end
        checks++;
        if (starts.size() != 3) begin
            errors++;
            $display("FAIL replay_notes got=%0d want=3", starts.size());
        end else begin
            checks++;
            if (starts[0] !== 2'd0 || starts[1] !== 2'd3 || starts[2] !== 2'd1 ||
                runs[0] != HOLD || runs[1] != HOLD || runs[2] != HOLD) begin
                errors++;
                $display("FAIL replay_seq got=%0d,%0d,%0d len=%0d,%0d,%0d want=0,3,1 len=4", starts[0], starts[1], starts[2], runs[0], runs[1], runs[2]);
            end
        end
        checks++;
        if (busy !== 1'b0 || rec_count !== 5'd3) begin
            errors++;
            $display("FAIL replay_end got busy=%0d rec=%0d want busy=0 rec=3", busy, rec_count);
        end
        $display("replay: notes=%0d rec=%0d", starts.size(), rec_count);
    endtask

    task automatic test_saturation();
        logic [1:0] played[$];
        logic [1:0] starts[$];
        logic       prev_en = 1'b0;
        logic [3:0] k;
        step(1'b1, 4'd0, 1'b0);
        for (int n = 0; n < 17; n++) begin
            k = 4'($urandom_range(1, 15));
            for (int i = 0; i < 9; i++) begin
                step(1'b0, (i == 0) ? k : 4'b0000, 1'b0);
                checks++;
                if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat_rec n=%0d cyc=%0d got=%b want=%b", n, i, {note_sel, note_en, busy, rec_count}, exp_vec());
                end
                if (i == 0) played.push_back(note_sel);
            end
        end
        checks++;
        if (rec_count !== 5'd16) begin
            errors++;
            $display("FAIL sat_count got=%0d want=16", rec_count);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b0, (i == 0) ? 4'b0001 : 4'b0000, (i == 0));
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL sat_run cyc=%0d got=%b want=%b", i, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1 && !prev_en) starts.push_back(note_sel);
            prev_en = (note_en === 1'b1);
        end
        checks++;
        if (starts.size() != 16) begin
            errors++;
            $display("FAIL sat_notes got=%0d want=16", starts.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                checks++;
                if (starts[j] !== played[j]) begin
                    errors++;
                    $display("FAIL sat_entry j=%0d got=%0d want=%0d", j, starts[j], played[j]);
                end
            end
        end
        $display("saturation: rec=%0d replayed=%0d", rec_count, starts.size());
    endtask
`else
    task automatic test_replay_ignored();
        int busy_seen = 0;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, (i == 0) ? 4'b1000 : 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0000, (i == 0));
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || rec_count !== 5'd0) begin
            errors++;
            $display("FAIL replay_ignored got busy_cycles=%0d rec=%0d want 0/0", busy_seen, rec_count);
        end
        $display("replay_ignored: busy_cycles=%0d rec=%0d", busy_seen, rec_count);
    endtask
`endif

    task automatic test_random();
        logic [3:0] k = 4'd0;
        logic       r;
        logic       rp;
        int         notes = 0;
        logic       prev_en = 1'b0;
        step(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) k = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 79) == 0);
            rp = ($urandom_range(0, 19) == 0);
            step(r, k, rp);
            checks++;
            if ({note_sel, note_en, busy, rec_count} !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d key=%b rst=%0d rp=%0d got=%b want=%b", i, k, r, rp, {note_sel, note_en, busy, rec_count}, exp_vec());
            end
            if (note_en === 1'b1 && !prev_en) notes++;
            prev_en = (note_en === 1'b1);
        end
        $display("random: cycles=400 notes=%0d", notes);
    endtask

    initial begin
        test_reset();
        test_tap();
        test_priority();
        test_long_hold();
        test_reset_mid_note();
        test_back_to_back();
`ifdef NOTE_SCHEDULER_REPLAY_EN
        test_replay();
        test_saturation();
`else
        test_replay_ignored();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
